dot_product_accel: RTL and testbench

DOT_PRODUCT_ACCEL -- requirements
Module: dot_product_accel

---
 rtl/dot_product_accel.sv | 67 ++++++
 tb/tb_dot_product_accel.sv | 123 ++++++++++++
 2 files changed

// File: rtl/dot_product_accel.sv
// dot_product_accel: sequential 8-element signed 32x32 dot product, one MAC per cycle
module dot_product_accel (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] a2,
    input  logic [31:0] a3,
    input  logic [31:0] a4,
    input  logic [31:0] a5,
    input  logic [31:0] a6,
    input  logic [31:0] a7,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    input  logic [31:0] b2,
    input  logic [31:0] b3,
    input  logic [31:0] b4,
    input  logic [31:0] b5,
    input  logic [31:0] b6,
    input  logic [31:0] b7,
    output logic        done,
    output logic [63:0] result
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic signed [31:0] a_r [8];
    logic signed [31:0] b_r [8];
    logic signed [63:0] acc, prod, sum;
    logic [2:0] idx;
    logic load, last;
    always_comb begin
        load = (state != RUN) && start;
        last = (state == RUN) && (idx == 3'd7);
        prod = 64'(a_r[idx]) * 64'(b_r[idx]);
        sum = acc + prod;
        state_nxt = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : state);
    end
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    // operands are only captured on an accepted start, so port changes mid-run are invisible
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc    <= '0;
            idx    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else if (load) begin
            a_r  <= '{a0, a1, a2, a3, a4, a5, a6, a7};
            b_r  <= '{b0, b1, b2, b3, b4, b5, b6, b7};
            acc  <= '0;
            idx  <= '0;
            done <= 1'b0;
        end else if (state == RUN) begin
            acc <= sum;
            idx <= idx + 3'd1;
            if (last) begin
                result <= sum;
                done   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dot_product_accel.sv
// tb_dot_product_accel: directed vectors with hand-computed dot products
module tb_dot_product_accel;
    logic        clk = 1'b0;
    logic        rst, start, done;
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [63:0] result;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_product_accel dut (
        .clk(clk), .rst(rst), .start(start),
        .a0(va[0]), .a1(va[1]), .a2(va[2]), .a3(va[3]),
        .a4(va[4]), .a5(va[5]), .a6(va[6]), .a7(va[7]),
        .b0(vb[0]), .b1(vb[1]), .b2(vb[2]), .b3(vb[3]),
        .b4(vb[4]), .b5(vb[5]), .b6(vb[6]), .b7(vb[7]),
        .done(done), .result(result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 8; i++) begin
            va[i] = a;
            vb[i] = b;
        end
    endtask

    // called at a negedge; start is sampled at the next edge (E0), result due at E8
    task automatic run(input string tag, input logic [63:0] exp, input bit scramble);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, {63'd0, done}, 64'd0);
        if (scramble)
            for (int i = 0; i < 8; i++) begin
                va[i] = $urandom | 32'h1;
                vb[i] = $urandom | 32'h1;
            end
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = scramble && (k == 3);
        end
        check({tag, "_e7_done"}, {63'd0, done}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_result"}, result, exp);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        set_ops(32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            va[i] = 32'(i + 1);
            vb[i] = 32'd1;
        end
        run("ramp", 64'd36, 1'b0);
        set_ops(32'd5, 32'd7);
        repeat (5) @(negedge clk);
        check("hold_done", {63'd0, done}, 64'd1);
        check("hold_result", result, 64'd36);

        set_ops(32'hFFFF_FFFF, 32'd2);
        run("neg", 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);

        set_ops(32'd0, 32'd0);
        va[0] = 32'h8000_0000;
        vb[0] = 32'h8000_0000;
        run("minint", 64'h4000_0000_0000_0000, 1'b0);

        set_ops(32'h8000_0000, 32'h8000_0000);
        run("wrap", 64'd0, 1'b0);

        set_ops(32'h0000_FFFF, 32'h0000_FFFF);
        run("ffff", 64'd34358689800, 1'b0);

        set_ops(32'd0, 32'd0);
        run("latched", 64'd0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            va[i] = 32'(i + 1);
            vb[i] = 32'd1;
        end
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_result", result, 64'd0);
        for (int i = 0; i < 8; i++) begin
            va[i] = 32'(i + 1);
            vb[i] = -32'(i + 1);
        end
        rst = 1'b1;
        run("post_reset", 64'hFFFF_FFFF_FFFF_FF34, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
